bf16_seq_mul: RTL and testbench
===============================

Name: bf16_seq_mul

Overview:
- Sequential bfloat16 multiplier; the stage directly upstream of the bfloat16 adder in the fused multiply-add datapath.
- Computes a*b and presents it on `mul` together with the addend `c_out`, aligned, for the adder stage.
- Significand product uses an 8-iteration shift-add loop.
- Result is truncated, not rounded, to match the adder's truncation.
- Valid/ready handshake on both sides.

Parameters:
- BIAS, 127, exponent bias.
- ITER, 8, shift-add iterations; equals significand width including the hidden bit. Fixed for bf16; do not override.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  16  bf16 multiplicand
- b  input  16  bf16 multiplier
- c_in  input  16  bf16 addend, passed through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream (adder) accepts result
- mul  output  16  bf16 product a*b
- c_out  output  16  registered copy of c_in
- ovf  output  1  product overflowed (saturated to inf)
- unf  output  1  product underflowed (flushed to zero)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0.
  - mul=0, c_out=0, ovf=0, unf=0; all internal registers cleared.
  - Any operation in flight is discarded; no output handshake follows.
- States: IDLE, MUL, NORM, DONE.
- in_ready = (state==IDLE). Combinational from state only; never depends on in_valid.
- IDLE:
  - Acceptance edge = in_valid&&in_ready.
  - On acceptance, latch a, b, c_in; sign = a[15]^b[15].
  - exp_sum = a[14:7] + b[14:7] - BIAS, as a 10-bit signed value.
  - acc = 0; mcand = {1,a[6:0]}; mplier = {1,b[6:0]}; cnt = 0.
  - Go to MUL.
- MUL, one iteration per cycle:
  - If mplier[0], acc += mcand << cnt (16-bit acc).
  - mplier >>= 1; cnt++.
  - After the iteration with cnt=7, go to NORM. Exactly 8 cycles in MUL.
- NORM, single cycle; registers mul, c_out, ovf, unf, then goes to DONE:
  - acc[15]=1: mant = acc[14:8], exp = exp_sum+1.
  - Otherwise: mant = acc[13:7], exp = exp_sum.
  - Then apply, in priority order:
    - 1. Either input NaN (exp field 0xFF, mantissa≠0), or inf×zero: mul = 0x7FC0; ovf=0, unf=0.
    - 2. Either input inf (the other nonzero): mul = {sign,0xFF,0}; ovf=0.
    - 3. Either input zero (exp field 0x00; subnormals are treated as zero): mul = {sign,15'h0}; unf=0.
    - 4. exp ≥ 255: mul = {sign,0xFF,0}; ovf=1.
    - 5. exp ≤ 0: mul = {sign,15'h0}; unf=1.
    - 6. Otherwise: mul = {sign, exp[7:0], mant}.
- DONE:
  - out_valid=1.
  - mul, c_out, ovf, unf held stable until out_valid&&out_ready at an edge.
  - On that edge go to IDLE; out_valid drops.
  - Outputs keep their last values after the handshake.
- Latency and throughput:
  - out_valid is first high after the 9th rising edge following the acceptance edge, regardless of operand class. Special cases do not shorten latency.
  - With out_ready held at 1, the next acceptance is possible 11 edges after the previous one.
- Backpressure: out_ready low in DONE holds DONE indefinitely; in_ready stays 0.
- in_valid while busy: ignored, not buffered.
- Reset asserted mid-MUL or mid-DONE: immediate return to reset values. After release, the first acceptance behaves as from power-up.

Test Plan:
- 1.0×1.0: a=0x3F80, b=0x3F80, c_in=0x4000, out_ready=1 → out_valid high 9 edges after acceptance; mul=0x3F80, c_out=0x4000, ovf=0, unf=0; next cycle in_ready=1.
- 1.5×1.5 and −2×3:
  - a=b=0x3FC0 → mul=0x4010 (normalize-by-shift path).
  - a=0xC000, b=0x4040 → mul=0xC0C0.
- Saturation/flush:
  - a=b=0x7F00 → mul=0x7F80, ovf=1.
  - a=b=0x0080 → mul=0x0000, unf=1.
- Specials:
  - a=0x8000, b=0x4040 → 0x8000.
  - a=0x7F80, b=0x0000 → 0x7FC0.
  - a=0x7FC1, b=0x3F80 → 0x7FC0.
  - a=0xFF80, b=0x4000 → 0xFF80.
  - Each with latency 9.
- Backpressure: complete 0x3FC0×0x3FC0 with out_ready=0 for 5 cycles while in_valid=1 and new operands are driven → mul stays 0x4010, out_valid stays 1, in_ready=0, new operands not taken. Then out_ready=1 → one handshake, then IDLE.
- Reset mid-op: accept a=0x4040, b=0x4040; drop rst_n 3 cycles later → out_valid=0, mul=0, in_ready=1 immediately. After release, 0x3F80×0x4000 → mul=0x4000 with no stale result emitted.

Source files
------------

// File: rtl/bf16_seq_mul_if.sv
// Operand/result bundle for the bf16 sequential multiplier.
// The master modport drives operands and accepts results; the slave modport is the multiplier.
interface bf16_seq_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] mul;
  logic [15:0] c_out;
  logic        ovf;
  logic        unf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, mul, c_out, ovf, unf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, mul, c_out, ovf, unf
  );
endinterface

// File: rtl/bf16_seq_mul.sv
// bf16 a*b (truncated) with addend c passed through; result valid 9 edges after acceptance.
// One operation in flight; DONE holds the result until out_ready, operands ignored while busy.
module bf16_seq_mul #(
  parameter int BIAS = 127,
  parameter int ITER = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  bf16_seq_mul_if.slave bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } opnd_t;

  state_t             state_q, state_d;
  opnd_t              opnd_q, opnd_d;
  logic signed [9:0]  exp_sum_q, exp_sum_d;
  logic [15:0]        acc_q, acc_d;
  logic [7:0]         mcand_q, mcand_d;
  logic [7:0]         mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        mul_q, mul_d;
  logic [15:0]        c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // Operand classification on the latched operands
  logic               sign;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [9:0]  exp_n;
  logic [6:0]         mant_n;

  assign sign   = opnd_q.a[15] ^ opnd_q.b[15];
  assign a_nan  = (opnd_q.a[14:7] == 8'hFF) && (opnd_q.a[6:0] != 7'h0);
  assign b_nan  = (opnd_q.b[14:7] == 8'hFF) && (opnd_q.b[6:0] != 7'h0);
  assign a_inf  = (opnd_q.a[14:7] == 8'hFF) && (opnd_q.a[6:0] == 7'h0);
  assign b_inf  = (opnd_q.b[14:7] == 8'hFF) && (opnd_q.b[6:0] == 7'h0);
  assign a_zero = (opnd_q.a[14:7] == 8'h00);
  assign b_zero = (opnd_q.b[14:7] == 8'h00);
  assign exp_n  = acc_q[15] ? exp_sum_q + 10'sd1 : exp_sum_q;
  assign mant_n = acc_q[15] ? acc_q[14:8] : acc_q[13:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid)                   state_d = MUL;
      MUL:  if (cnt_q == CW'(ITER - 1))         state_d = NORM;
      NORM:                                     state_d = DONE;
      DONE: if (bus.out_ready)                  state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  always_comb begin
    opnd_d    = opnd_q;
    exp_sum_d = exp_sum_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    mul_d     = mul_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        opnd_d    = '{a: bus.a, b: bus.b, c: bus.c_in};
        exp_sum_d = signed'({2'b00, bus.a[14:7]}) + signed'({2'b00, bus.b[14:7]}) - 10'(BIAS);
        acc_d     = 16'h0;
        mcand_d   = {1'b1, bus.a[6:0]};
        mplier_d  = {1'b1, bus.b[6:0]};
        cnt_d     = '0;
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + ({8'h00, mcand_q} << cnt_q);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      NORM: begin
        c_out_d = opnd_q.c;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        // Specials take priority over range checks; inf*0 is the invalid case
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          mul_d = 16'h7FC0;
        end else if (a_inf || b_inf) begin
          mul_d = {sign, 8'hFF, 7'h00};
        end else if (a_zero || b_zero) begin
          mul_d = {sign, 15'h0000};
        end else if (exp_n >= 10'sd255) begin
          mul_d = {sign, 8'hFF, 7'h00};
          ovf_d = 1'b1;
        end else if (exp_n <= 10'sd0) begin
          mul_d = {sign, 15'h0000};
          unf_d = 1'b1;
        end else begin
          mul_d = {sign, exp_n[7:0], mant_n};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q    <= '0;
      exp_sum_q <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      mul_q     <= '0;
      c_out_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      opnd_q    <= opnd_d;
      exp_sum_q <= exp_sum_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      mul_q     <= mul_d;
      c_out_q   <= c_out_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.mul   = mul_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_bf16_seq_mul.sv
// Directed and random bench for bf16_seq_mul against an integer-arithmetic bf16 product model.
// Covers latency, specials, saturation/flush, backpressure and mid-operation reset.
module tb_bf16_seq_mul;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  bf16_seq_mul_if bus_i ();

  bf16_seq_mul #(.BIAS(127), .ITER(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, unf, product} from the bf16 rules using plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, m, prod;
    logic s, an, bn, ai, bi, az, bz;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);  eb = int'(b[14:7]);
    ma = int'(a[6:0]);   mb = int'(b[6:0]);
    an = (ea == 255) && (ma != 0);  bn = (eb == 255) && (mb != 0);
    ai = (ea == 255) && (ma == 0);  bi = (eb == 255) && (mb == 0);
    az = (ea == 0);                 bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {2'b00, 16'h7FC0};
    if (ai || bi) return {2'b00, s, 8'hFF, 7'h00};
    if (az || bz) return {2'b00, s, 15'h0000};
    prod = (128 + ma) * (128 + mb);
    e    = ea + eb - 127;
    if (prod >= 32768) begin
      m = (prod / 256) % 128;
      e = e + 1;
    end else begin
      m = (prod / 128) % 128;
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 7'h00};
    if (e <= 0)   return {2'b01, s, 15'h0000};
    return {2'b00, s, 8'(e), 7'(m)};
  endfunction

  function automatic logic [15:0] rnd_bf16();
    int       k;
    logic [7:0] e;
    logic [6:0] m;
    k = int'($urandom_range(0, 19));
    m = 7'($urandom);
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k == 2) begin e = 8'hFF; m = 7'h00; end
    else if (k < 6)  e = 8'($urandom_range(0, 255));
    else             e = 8'($urandom_range(90, 165));
    return {1'($urandom), e, m};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c);
    int n;
    logic [17:0] e;
    e = model(a, b);
    n = 0;
    while (!bus_i.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, ".in_ready"}, 16'(bus_i.in_ready), 16'd1);
    bus_i.in_valid = 1'b1;
    bus_i.a = a; bus_i.b = b; bus_i.c_in = c;
    @(posedge clk); #1;
    bus_i.in_valid = 1'b0;
    n = 0;
    while (!bus_i.out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk({tag, ".latency"}, 16'(n), 16'd9);
    chk({tag, ".mul"}, bus_i.mul, e[15:0]);
    chk({tag, ".c_out"}, bus_i.c_out, c);
    chk({tag, ".ovf_unf"}, {14'h0, bus_i.ovf, bus_i.unf}, {14'h0, e[17:16]});
    if (bus_i.out_ready) begin
      @(posedge clk); #1;
      chk({tag, ".idle_ready"}, {15'h0, bus_i.in_ready}, 16'd1);
      chk({tag, ".valid_drop"}, {15'h0, bus_i.out_valid}, 16'd0);
    end
  endtask

  initial begin
    logic [15:0] da [9];
    logic [15:0] db [9];
    da = '{16'h3F80, 16'h3FC0, 16'hC000, 16'h7F00, 16'h0080, 16'h8000, 16'h7F80, 16'h7FC1, 16'hFF80};
    db = '{16'h3F80, 16'h3FC0, 16'h4040, 16'h7F00, 16'h0080, 16'h4040, 16'h0000, 16'h3F80, 16'h4000};

    rst_n = 1'b0;
    bus_i.in_valid = 1'b0;
    bus_i.a = 16'h0; bus_i.b = 16'h0; bus_i.c_in = 16'h0;
    bus_i.out_ready = 1'b1;
    #2;
    chk("rst.in_ready", {15'h0, bus_i.in_ready}, 16'd1);
    chk("rst.out_valid", {15'h0, bus_i.out_valid}, 16'd0);
    chk("rst.mul", bus_i.mul, 16'h0000);
    chk("rst.c_out", bus_i.c_out, 16'h0000);
    chk("rst.flags", {14'h0, bus_i.ovf, bus_i.unf}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Expected products for the directed set, written out independently of the model
    run_op("one_x_one", 16'h3F80, 16'h3F80, 16'h4000);
    chk("dir.0x3F80", bus_i.mul, 16'h3F80);
    run_op("d1p5", 16'h3FC0, 16'h3FC0, 16'h1111);
    chk("dir.0x4010", bus_i.mul, 16'h4010);
    run_op("dm2x3", 16'hC000, 16'h4040, 16'h2222);
    chk("dir.0xC0C0", bus_i.mul, 16'hC0C0);
    run_op("dovf", 16'h7F00, 16'h7F00, 16'h3333);
    chk("dir.ovf", {bus_i.mul[15:1], bus_i.ovf}, {15'h3FC0, 1'b1});
    run_op("dunf", 16'h0080, 16'h0080, 16'h4444);
    chk("dir.unf", {bus_i.mul[15:1], bus_i.unf}, {15'h0000, 1'b1});
    run_op("dnegzero", 16'h8000, 16'h4040, 16'h5555);
    chk("dir.0x8000", bus_i.mul, 16'h8000);
    run_op("dinfzero", 16'h7F80, 16'h0000, 16'h6666);
    chk("dir.inf0", bus_i.mul, 16'h7FC0);
    run_op("dnan", 16'h7FC1, 16'h3F80, 16'h7777);
    chk("dir.nan", bus_i.mul, 16'h7FC0);
    run_op("dneginf", 16'hFF80, 16'h4000, 16'h8888);
    chk("dir.-inf", bus_i.mul, 16'hFF80);
    for (int i = 0; i < 9; i++) run_op("dtab_sw", db[i], da[i], 16'(i));

    for (int i = 0; i < 40; i++) run_op("rand", rnd_bf16(), rnd_bf16(), 16'($urandom));

    bus_i.out_ready = 1'b0;
    run_op("bp", 16'h3FC0, 16'h3FC0, 16'h4000);
    bus_i.in_valid = 1'b1;
    bus_i.a = 16'h4040; bus_i.b = 16'h4040; bus_i.c_in = 16'h9999;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.mul_hold", bus_i.mul, 16'h4010);
      chk("bp.valid_hold", {15'h0, bus_i.out_valid}, 16'd1);
      chk("bp.in_ready", {15'h0, bus_i.in_ready}, 16'd0);
    end
    bus_i.in_valid = 1'b0;
    bus_i.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", {15'h0, bus_i.out_valid}, 16'd0);
    chk("bp.release_ready", {15'h0, bus_i.in_ready}, 16'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("bp.not_taken_mul", bus_i.mul, 16'h4010);
    chk("bp.not_taken_cout", bus_i.c_out, 16'h4000);

    bus_i.in_valid = 1'b1;
    bus_i.a = 16'h4040; bus_i.b = 16'h4040; bus_i.c_in = 16'hABCD;
    @(posedge clk); #1;
    bus_i.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid.out_valid", {15'h0, bus_i.out_valid}, 16'd0);
    chk("rstmid.mul", bus_i.mul, 16'h0000);
    chk("rstmid.c_out", bus_i.c_out, 16'h0000);
    chk("rstmid.in_ready", {15'h0, bus_i.in_ready}, 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_rst", 16'h3F80, 16'h4000, 16'h1234);
    chk("post_rst.0x4000", bus_i.mul, 16'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
